// File: rtl/attention_feeder.sv
// attention_feeder: streams four q/k operand pairs to an exp() engine and
// captures the single result, aborting the wait after TIMEOUT cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data operand file write (0-3 = q0..q3, 4-7 = k0..k3)
//   start                    request one transaction (honoured in IDLE only)
//   tx_data/tx_vld/tx_rdy    operand stream toward the engine
//   res_data/res_vld/res_rdy result return from the engine
//   result                   last captured result
//   busy/done/timeout_err    status: not idle, end pulse, sticky wait abort
module attention_feeder #(
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_we,
   input  logic [2:0] cfg_addr,
   input  logic [7:0] cfg_data,
   input  logic       start,
   output logic [7:0] tx_data,
   output logic       tx_vld,
   input  logic       tx_rdy,
   input  logic [8:0] res_data,
   input  logic       res_vld,
   output logic       res_rdy,
   output logic [8:0] result,
   output logic       busy,
   output logic       done,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_RES,
      DONE
   } state_t;

   // Last wait count; reaching it without a transfer aborts the wait.
   localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] ops_q [8];
   logic [7:0] ops_d [8];
   logic [2:0] beat_q, beat_d;
   logic [7:0] tcnt_q, tcnt_d;
   logic [8:0] result_q, result_d;
   logic       terr_q, terr_d;
   logic [2:0] op_idx;

   // Even beats pick q[n/2] (entries 0-3), odd beats pick k[n/2] (4-7).
   assign op_idx = {beat_q[0], beat_q[2:1]};

   always_comb begin
      state_d  = state_q;
      ops_d    = ops_q;
      beat_d   = beat_q;
      tcnt_d   = tcnt_q;
      result_d = result_q;
      terr_d   = terr_q;
      tx_vld   = 1'b0;
      tx_data  = 8'h00;
      res_rdy  = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cfg_we) begin
               ops_d[cfg_addr] = cfg_data;
            end
            if (start) begin
               state_d = SEND;
               beat_d  = 3'd0;
               terr_d  = 1'b0;
            end
         end
         SEND: begin
            tx_vld  = 1'b1;
            tx_data = ops_q[op_idx];
            if (tx_rdy) begin
               beat_d = beat_q + 3'd1;
               if (beat_q == 3'd7) begin
                  state_d = WAIT_RES;
                  tcnt_d  = 8'd0;
               end
            end
         end
         WAIT_RES: begin
            res_rdy = 1'b1;
            // A transfer on the last count wins over the abort.
            if (res_vld) begin
               result_d = res_data;
               state_d  = DONE;
            end else if (tcnt_q == T_LAST) begin
               terr_d  = 1'b1;
               state_d = DONE;
            end else begin
               tcnt_d = tcnt_q + 8'd1;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ops_q    <= '{default: 8'h00};
         beat_q   <= 3'd0;
         tcnt_q   <= 8'd0;
         result_q <= 9'd0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ops_q    <= ops_d;
         beat_q   <= beat_d;
         tcnt_q   <= tcnt_d;
         result_q <= result_d;
         terr_q   <= terr_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign result      = result_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_attention_feeder.sv
// tb_attention_feeder: directed scenarios for attention_feeder.
// Inputs change #1 after a rising edge; outputs are sampled there too.
module tb_attention_feeder;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_data;
   logic       start;
   logic [7:0] tx_data;
   logic       tx_vld;
   logic       tx_rdy;
   logic [8:0] res_data;
   logic       res_vld;
   logic       res_rdy;
   logic [8:0] result;
   logic       busy;
   logic       done;
   logic       timeout_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   attention_feeder #(.TIMEOUT(255)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .start      (start),
      .tx_data    (tx_data),
      .tx_vld     (tx_vld),
      .tx_rdy     (tx_rdy),
      .res_data   (res_data),
      .res_vld    (res_vld),
      .res_rdy    (res_rdy),
      .result     (result),
      .busy       (busy),
      .done       (done),
      .timeout_err(timeout_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Byte b of a sequence written most-significant first.
   function automatic logic [7:0] seqb(input logic [63:0] s, input int b);
      return s[63-8*b -: 8];
   endfunction

   // v holds q0,q1,q2,q3,k0,k1,k2,k3 from the most significant byte down.
   task automatic load_ops(input logic [63:0] v);
      for (int i = 0; i < 8; i++) begin
         cfg_we   = 1'b1;
         cfg_addr = 3'(i);
         cfg_data = seqb(v, i);
         tick();
      end
      cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'h00;
      start = 1'b0; tx_rdy = 1'b0; res_vld = 1'b0; res_data = 9'd0;
      tick(); tick(); tick();
      n_chk++;
      if ({tx_vld, tx_data, res_rdy, busy, done, timeout_err, result} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got vld=%b data=%h rrdy=%b busy=%b done=%b terr=%b res=%h, expected all 0",
                  tx_vld, tx_data, res_rdy, busy, done, timeout_err, result);
      end
      rst = 1'b0;
      tick(); tick();
      n_chk++;
      if (tx_vld !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_idle: got vld=%b busy=%b, expected 0 0", tx_vld, busy);
      end
   endtask

   task automatic test_basic();
      load_ops(64'h4020C07F_40104081);
      tx_rdy = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      for (int b = 0; b < 8; b++) begin
         n_chk++;
         if (tx_vld !== 1'b1 || tx_data !== seqb(64'h40402010_C0407F81, b)) begin
            n_fail++;
            $display("FAIL basic_beat%0d: got vld=%b data=%h, expected vld=1 data=%h",
                     b, tx_vld, tx_data, seqb(64'h40402010_C0407F81, b));
         end
         tick();
      end
      n_chk++;
      if (tx_vld !== 1'b0 || tx_data !== 8'h00 || res_rdy !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_wait_entry: got vld=%b data=%h rrdy=%b busy=%b, expected 0 00 1 1",
                  tx_vld, tx_data, res_rdy, busy);
      end
      res_data = 9'h1A5; res_vld = 1'b1; tick(); res_vld = 1'b0;
      n_chk++;
      if (done !== 1'b1 || result !== 9'h1A5 || res_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done: got done=%b res=%h rrdy=%b, expected 1 1a5 0", done, result, res_rdy);
      end
      tick();
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== 9'h1A5) begin
         n_fail++;
         $display("FAIL basic_after_done: got done=%b busy=%b res=%h, expected 0 0 1a5", done, busy, result);
      end
   endtask

   task automatic test_stall();
      load_ops(64'h01020304_F1F2F3F4);
      res_data = 9'h0FF; res_vld = 1'b1;
      tick(); tick();
      n_chk++;
      if (result !== 9'h1A5 || res_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_res_idle_ignored: got res=%h rrdy=%b, expected 1a5 0", result, res_rdy);
      end
      res_vld = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      for (int p = 0; p < 4; p++) begin
         tx_rdy = 1'b1;
         n_chk++;
         if (tx_vld !== 1'b1 || tx_data !== seqb(64'h01F102F2_03F304F4, 2*p)) begin
            n_fail++;
            $display("FAIL stall_first%0d: got vld=%b data=%h, expected 1 %h",
                     p, tx_vld, tx_data, seqb(64'h01F102F2_03F304F4, 2*p));
         end
         tick();
         tx_rdy = 1'b0;
         n_chk++;
         if (tx_vld !== 1'b1 || tx_data !== seqb(64'h01F102F2_03F304F4, 2*p+1)) begin
            n_fail++;
            $display("FAIL stall_held%0d: got vld=%b data=%h, expected 1 %h",
                     p, tx_vld, tx_data, seqb(64'h01F102F2_03F304F4, 2*p+1));
         end
         tick();
         tx_rdy = 1'b1;
         n_chk++;
         if (tx_vld !== 1'b1 || tx_data !== seqb(64'h01F102F2_03F304F4, 2*p+1)) begin
            n_fail++;
            $display("FAIL stall_second%0d: got vld=%b data=%h, expected 1 %h",
                     p, tx_vld, tx_data, seqb(64'h01F102F2_03F304F4, 2*p+1));
         end
         tick();
      end
      n_chk++;
      if (tx_vld !== 1'b0 || res_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_wait_entry: got vld=%b rrdy=%b, expected 0 1", tx_vld, res_rdy);
      end
      tick(); tick();
      res_data = 9'h0C3; res_vld = 1'b1; tick(); res_vld = 1'b0;
      n_chk++;
      if (done !== 1'b1 || result !== 9'h0C3) begin
         n_fail++;
         $display("FAIL stall_result: got done=%b res=%h, expected 1 0c3", done, result);
      end
      tick();
   endtask

   task automatic test_timeout();
      int k;
      tx_rdy = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      for (int b = 0; b < 8; b++) tick();
      k = 0;
      while (done !== 1'b1 && k < 400) begin
         tick();
         k++;
      end
      n_chk++;
      if (k != 255) begin
         n_fail++;
         $display("FAIL timeout_cycles: got done after %0d cycles, expected 255", k);
      end
      n_chk++;
      if (timeout_err !== 1'b1 || result !== 9'h0C3) begin
         n_fail++;
         $display("FAIL timeout_flag: got terr=%b res=%h, expected 1 0c3", timeout_err, result);
      end
      tick();
      n_chk++;
      if (timeout_err !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_sticky: got terr=%b busy=%b, expected 1 0", timeout_err, busy);
      end
      start = 1'b1; tick(); start = 1'b0;
      n_chk++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_clear_on_start: got terr=%b busy=%b, expected 0 1", timeout_err, busy);
      end
      for (int b = 0; b < 8; b++) tick();
      for (int c = 0; c < 254; c++) tick();
      n_chk++;
      if (res_rdy !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_edge_waiting: got rrdy=%b done=%b, expected 1 0", res_rdy, done);
      end
      res_data = 9'h155; res_vld = 1'b1; tick(); res_vld = 1'b0;
      n_chk++;
      if (done !== 1'b1 || result !== 9'h155 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_edge_capture: got done=%b res=%h terr=%b, expected 1 155 0",
                  done, result, timeout_err);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      load_ops(64'h55667788_99AABBCC);
      tx_rdy = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      for (int b = 0; b < 4; b++) tick();
      rst = 1'b1; tick();
      n_chk++;
      if (tx_vld !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || result !== 9'd0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got vld=%b busy=%b data=%h res=%h, expected 0 0 00 000",
                  tx_vld, busy, tx_data, result);
      end
      rst = 1'b0;
      tick(); tick(); tick();
      n_chk++;
      if (tx_vld !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_no_beat: got vld=%b busy=%b, expected 0 0", tx_vld, busy);
      end
      start = 1'b1; tick(); start = 1'b0;
      for (int b = 0; b < 8; b++) begin
         n_chk++;
         if (tx_vld !== 1'b1 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_zero_op%0d: got vld=%b data=%h, expected 1 00", b, tx_vld, tx_data);
         end
         tick();
      end
      res_data = 9'h0AA; res_vld = 1'b1; tick(); res_vld = 1'b0;
      tick();
      load_ops(64'h55667788_99AABBCC);
      start = 1'b1; tick(); start = 1'b0;
      for (int b = 0; b < 8; b++) begin
         n_chk++;
         if (tx_vld !== 1'b1 || tx_data !== seqb(64'h559966AA_77BB88CC, b)) begin
            n_fail++;
            $display("FAIL rstmid_reload%0d: got vld=%b data=%h, expected 1 %h",
                     b, tx_vld, tx_data, seqb(64'h559966AA_77BB88CC, b));
         end
         tick();
      end
      res_data = 9'h123; res_vld = 1'b1; tick(); res_vld = 1'b0;
      n_chk++;
      if (done !== 1'b1 || result !== 9'h123) begin
         n_fail++;
         $display("FAIL rstmid_result: got done=%b res=%h, expected 1 123", done, result);
      end
      tick();
   endtask

   task automatic test_busy_ignore();
      load_ops(64'h0A0B0C0D_1A1B1C1D);
      tx_rdy = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      for (int b = 0; b < 8; b++) begin
         n_chk++;
         if (tx_vld !== 1'b1 || tx_data !== seqb(64'h0A1A0B1B_0C1C0D1D, b)) begin
            n_fail++;
            $display("FAIL busy_seq%0d: got vld=%b data=%h, expected 1 %h",
                     b, tx_vld, tx_data, seqb(64'h0A1A0B1B_0C1C0D1D, b));
         end
         if (b == 2) begin
            cfg_we = 1'b1; cfg_addr = 3'd7; cfg_data = 8'hEE; start = 1'b1;
         end
         tick();
         cfg_we = 1'b0; start = 1'b0;
      end
      cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 8'h77; start = 1'b1;
      tick();
      cfg_we = 1'b0; start = 1'b0;
      res_data = 9'h0EE; res_vld = 1'b1; tick(); res_vld = 1'b0;
      n_chk++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_done: got done=%b, expected 1", done);
      end
      start = 1'b1; tick(); start = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || tx_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start_in_done: got busy=%b vld=%b, expected 0 0", busy, tx_vld);
      end
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h11; start = 1'b1;
      tick();
      cfg_we = 1'b0; start = 1'b0;
      for (int b = 0; b < 8; b++) begin
         n_chk++;
         if (tx_vld !== 1'b1 || tx_data !== seqb(64'h111A0B1B_0C1C0D1D, b)) begin
            n_fail++;
            $display("FAIL busy_same_cycle%0d: got vld=%b data=%h, expected 1 %h",
                     b, tx_vld, tx_data, seqb(64'h111A0B1B_0C1C0D1D, b));
         end
         tick();
      end
      res_data = 9'h042; res_vld = 1'b1; tick(); res_vld = 1'b0;
      n_chk++;
      if (done !== 1'b1 || result !== 9'h042) begin
         n_fail++;
         $display("FAIL busy_final_result: got done=%b res=%h, expected 1 042", done, result);
      end
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_timeout();
      test_reset_mid();
      test_busy_ignore();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
